// File: rtl/gpio_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gpio_cmd_sequencer
// Description : Avalon-MM master that runs a queue of PIO commands
//               (write data, write direction, delay, read, poll-until-match)
//               against a 32-bit bidirectional PIO and returns read / poll
//               results on a response stream.
//               Optional poll timeout: define GPIO_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_cmd_sequencer #(
   parameter int CMD_DEPTH  = 4,
   parameter int POLL_LIMIT = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_arg,
   input  logic [31:0] cmd_mask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout,
   output logic        busy,
   output logic [1:0]  pio_address,
   output logic        pio_chipselect,
   output logic        pio_write_n,
   output logic [31:0] pio_writedata,
   input  logic [31:0] pio_readdata
);

   localparam int c_PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int c_CNT_W = c_PTR_W + 1;

   localparam logic [2:0] c_OP_WR_DATA = 3'd0;
   localparam logic [2:0] c_OP_WR_DIR  = 3'd1;
   localparam logic [2:0] c_OP_DELAY   = 3'd2;
   localparam logic [2:0] c_OP_READ    = 3'd3;
   localparam logic [2:0] c_OP_POLL    = 3'd4;

   // Reject configurations the FIFO pointer arithmetic cannot support.
   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || POLL_LIMIT < 1) begin : g_bad_param
      $error("gpio_cmd_sequencer: CMD_DEPTH must be a power of 2 >= 2 and POLL_LIMIT >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_DLY  = 3'd2,
      S_RD_A = 3'd3,
      S_RD_C = 3'd4,
      S_RSP  = 3'd5
   } state_t;

   // ---------------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------------
   logic [2:0]         r_fifo_op   [CMD_DEPTH];
   logic [31:0]        r_fifo_arg  [CMD_DEPTH];
   logic [31:0]        r_fifo_mask [CMD_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   state_t             r_state;
   logic [2:0]         r_op;
   logic [31:0]        r_arg;
   logic [31:0]        r_mask;
   logic [31:0]        r_dly_cnt;
   logic               r_rsp_valid;
   logic [31:0]        r_rsp_data;
   logic [1:0]         r_pio_address;
   logic               r_pio_chipselect;
   logic               r_pio_write_n;
   logic [31:0]        r_pio_writedata;

   logic               w_push;
   logic               w_pop;
   logic               w_match;

   assign cmd_ready = (r_count != c_CNT_W'(CMD_DEPTH));
   assign w_push    = cmd_valid & cmd_ready;
   // A response still waiting for acceptance blocks further pops so that
   // responses come back in command order.
   assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && !r_rsp_valid;
   assign w_match   = ((pio_readdata & r_mask) == (r_arg & r_mask));

   // FIFO storage: written on push, no reset needed for the payload.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_op[r_wr_ptr]   <= cmd_op;
         r_fifo_arg[r_wr_ptr]  <= cmd_arg;
         r_fifo_mask[r_wr_ptr] <= cmd_mask;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at CMD_DEPTH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - c_CNT_W'(1);
      end
   end

`ifdef GPIO_SEQ_TIMEOUT_EN
   localparam int c_POLL_W = $clog2(POLL_LIMIT + 1);
   logic [c_POLL_W-1:0] r_poll_cnt;
   logic                r_rsp_timeout;
   assign rsp_timeout = r_rsp_timeout;
`else
   assign rsp_timeout = 1'b0;
`endif

   // Sequencer FSM: executes one command at a time and drives the PIO bus.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state          <= S_IDLE;
         r_op             <= '0;
         r_arg            <= '0;
         r_mask           <= '0;
         r_dly_cnt        <= '0;
         r_rsp_valid      <= 1'b0;
         r_rsp_data       <= '0;
         r_pio_address    <= 2'd0;
         r_pio_chipselect <= 1'b0;
         r_pio_write_n    <= 1'b1;
         r_pio_writedata  <= '0;
`ifdef GPIO_SEQ_TIMEOUT_EN
         r_poll_cnt       <= '0;
         r_rsp_timeout    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_op   <= r_fifo_op[r_rd_ptr];
                  r_arg  <= r_fifo_arg[r_rd_ptr];
                  r_mask <= r_fifo_mask[r_rd_ptr];
`ifdef GPIO_SEQ_TIMEOUT_EN
                  r_poll_cnt <= '0;
`endif
                  case (r_fifo_op[r_rd_ptr])
                     c_OP_WR_DATA, c_OP_WR_DIR: begin
                        // Strobe is launched here so it is visible for
                        // exactly the WR cycle.
                        r_state          <= S_WR;
                        r_pio_chipselect <= 1'b1;
                        r_pio_write_n    <= 1'b0;
                        r_pio_address    <= (r_fifo_op[r_rd_ptr] == c_OP_WR_DIR) ? 2'd1 : 2'd0;
                        r_pio_writedata  <= r_fifo_arg[r_rd_ptr];
                     end
                     c_OP_DELAY: begin
                        r_state   <= S_DLY;
                        r_dly_cnt <= r_fifo_arg[r_rd_ptr];
                     end
                     c_OP_READ, c_OP_POLL: begin
                        r_state          <= S_RD_A;
                        r_pio_chipselect <= 1'b1;
                        r_pio_write_n    <= 1'b1;
                        r_pio_address    <= 2'd0;
                     end
                     default: r_state <= S_IDLE;   // reserved opcode: dropped
                  endcase
               end
            end

            S_WR: begin
               r_pio_chipselect <= 1'b0;
               r_pio_write_n    <= 1'b1;
               r_pio_address    <= 2'd0;
               r_state          <= S_IDLE;
            end

            S_DLY: begin
               // A count of 0 or 1 both give a single delay cycle.
               if (r_dly_cnt <= 32'd1) r_state <= S_IDLE;
               else                    r_dly_cnt <= r_dly_cnt - 32'd1;
            end

            S_RD_A: begin
               r_pio_chipselect <= 1'b0;
               r_state          <= S_RD_C;
            end

            S_RD_C: begin
               // The PIO readdata register now holds the address-0 sample
               // requested during RD_A.
               r_rsp_data <= pio_readdata;
               if (r_op == c_OP_READ || w_match) begin
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RSP;
`ifdef GPIO_SEQ_TIMEOUT_EN
                  r_rsp_timeout <= 1'b0;
               end else if (r_poll_cnt == c_POLL_W'(POLL_LIMIT - 1)) begin
                  r_rsp_valid   <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  r_state       <= S_RSP;
               end else begin
                  r_poll_cnt       <= r_poll_cnt + c_POLL_W'(1);
                  r_pio_chipselect <= 1'b1;
                  r_pio_write_n    <= 1'b1;
                  r_pio_address    <= 2'd0;
                  r_state          <= S_RD_A;
               end
`else
               end else begin
                  r_pio_chipselect <= 1'b1;
                  r_pio_write_n    <= 1'b1;
                  r_pio_address    <= 2'd0;
                  r_state          <= S_RD_A;
               end
`endif
            end

            S_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid      = r_rsp_valid;
   assign rsp_data       = r_rsp_data;
   assign pio_address    = r_pio_address;
   assign pio_chipselect = r_pio_chipselect;
   assign pio_write_n    = r_pio_write_n;
   assign pio_writedata  = r_pio_writedata;
   assign busy           = (r_count != '0) || (r_state != S_IDLE) || r_rsp_valid;

endmodule
`default_nettype wire
